// File: rtl/roba_dot_accumulator.sv
// roba_dot_accumulator: sums len unsigned RoBA products into one saturating
// dot-product result, held until the consumer takes it.
// Ports: clk, rst (sync, active-high); start/len job request;
//        prod_valid/prod_ready/prod_data product input handshake;
//        out_valid/out_ready/out_data/out_sat result handshake; busy.
module roba_dot_accumulator #(
    parameter int A_BW   = 8,
    parameter int B_BW   = 8,
    parameter int ACC_BW = 32,
    parameter int LEN_BW = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [LEN_BW-1:0]      len,
    input  logic                   prod_valid,
    output logic                   prod_ready,
    input  logic [A_BW+B_BW:0]     prod_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_BW-1:0]      out_data,
    output logic                   out_sat,
    output logic                   busy
);

    localparam int P_BW = A_BW + B_BW + 1;
    localparam logic [LEN_BW-1:0] ONE = LEN_BW'(1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ACC_BW-1:0]   acc;
    logic [LEN_BW-1:0]   count;
    logic                sat;

    logic                launch;
    logic                accept;
    logic [ACC_BW:0]     sum;
    logic                carry;

    assign launch = (state == IDLE) && start && (len != '0);
    assign accept = prod_valid && prod_ready;

    // Sum one bit wider than the accumulator; the top bit is the overflow.
    assign sum   = {1'b0, acc} + {{(ACC_BW + 1 - P_BW){1'b0}}, prod_data};
    assign carry = sum[ACC_BW];

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (launch) state_next = ACCUM;
            end
            ACCUM: begin
                if (accept && (count == ONE)) state_next = HOLD;
            end
            HOLD: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
            sat   <= 1'b0;
        end else begin
            state <= state_next;
            if (launch) begin
                count <= len;
                acc   <= '0;
                sat   <= 1'b0;
            end else if (accept) begin
                count <= count - ONE;
                // Sticky: once pinned at all ones, stay there for the job.
                if (sat || carry) begin
                    acc <= '1;
                    sat <= 1'b1;
                end else begin
                    acc <= sum[ACC_BW-1:0];
                end
            end
        end
    end

    assign prod_ready = (state == ACCUM);
    assign out_valid  = (state == HOLD);
    assign out_data   = acc;
    assign out_sat    = sat;
    assign busy       = (state != IDLE);

endmodule
